// File: rtl/r_inst_fetch.sv
// r_inst_fetch
// Instruction-fetch stage feeding the R-type datapath. A small loadable
// instruction memory is walked by a PC; each R-type word is presented over a
// valid/ready handshake. Fetching stops on the end-of-program sentinel, on any
// non-R-type opcode (flagged as illegal) or after the last memory address.
module r_inst_fetch #(
   parameter int          ADDR_W   = 6,
   parameter logic [31:0] END_MARK = 32'hFFFF_FFFF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              imem_we,
   input  logic [ADDR_W-1:0] imem_waddr,
   input  logic [31:0]       imem_wdata,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [31:0]       inst,
   output logic [4:0]        rs,
   output logic [4:0]        rt,
   output logic [4:0]        rd,
   output logic [4:0]        shamt,
   output logic [5:0]        funct,
   output logic [ADDR_W-1:0] pc,
   output logic              busy,
   output logic              halted,
   output logic              illegal,
   output logic [15:0]       inst_count
);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_VALID = 2'd2;
   localparam logic [1:0] ST_HALT  = 2'd3;

   localparam int DEPTH = 2 ** ADDR_W;

   logic [31:0]       r_mem [DEPTH];
   logic [1:0]        r_state;
   logic [ADDR_W-1:0] r_pc;
   logic [31:0]       r_inst;
   logic              r_out_valid;
   logic              r_illegal;
   logic [15:0]       r_count;

   logic [31:0]       w_word;
   logic [5:0]        w_opcode;
   logic              w_is_end;
   logic              w_is_illegal;
   logic              w_mem_wr_en;
   logic              w_pc_last;
   logic              w_accept;
   logic              w_count_sat;
   logic              w_idle_or_halt;

   // The memory may only be rewritten while nothing is being fetched, so a
   // program cannot change underneath a running fetch sequence.
   assign w_idle_or_halt = (r_state == ST_IDLE) || (r_state == ST_HALT);
   assign w_mem_wr_en    = imem_we && w_idle_or_halt;

   // Asynchronous read of the word the PC points at.
   assign w_word       = r_mem[r_pc];
   assign w_opcode     = w_word[31:26];
   assign w_is_end     = (w_word == END_MARK);
   assign w_is_illegal = (w_opcode != 6'd0);

   assign w_pc_last   = (r_pc == {ADDR_W{1'b1}});
   assign w_accept    = r_out_valid && out_ready;
   assign w_count_sat = (r_count == 16'hFFFF);

   // Instruction memory write port; contents deliberately survive reset.
   always_ff @(posedge clk) begin
      if (w_mem_wr_en) begin
         r_mem[imem_waddr] <= imem_wdata;
      end
   end

   // Fetch sequencer: walks the PC, captures R-type words and handles the
   // handshake, halting on sentinel, illegal opcode or the last address.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state     <= ST_IDLE;
         r_pc        <= '0;
         r_inst      <= '0;
         r_out_valid <= 1'b0;
         r_illegal   <= 1'b0;
         r_count     <= '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_pc    <= '0;
                  r_state <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (w_is_end) begin
                  r_state <= ST_HALT;
               end else if (w_is_illegal) begin
                  r_illegal <= 1'b1;
                  r_state   <= ST_HALT;
               end else begin
                  r_inst      <= w_word;
                  r_out_valid <= 1'b1;
                  r_state     <= ST_VALID;
               end
            end
            ST_VALID: begin
               if (w_accept) begin
                  r_out_valid <= 1'b0;
                  if (!w_count_sat) begin
                     r_count <= r_count + 16'd1;
                  end
                  if (w_pc_last) begin
                     r_state <= ST_HALT;
                  end else begin
                     r_pc    <= r_pc + ADDR_W'(1);
                     r_state <= ST_FETCH;
                  end
               end
            end
            ST_HALT: begin
               if (start) begin
                  r_pc      <= '0;
                  r_illegal <= 1'b0;
                  r_count   <= '0;
                  r_state   <= ST_FETCH;
               end
            end
            default: begin
               r_state <= ST_IDLE;
            end
         endcase
      end
   end

   // Field decode is purely combinational from the held instruction.
   assign rs    = r_inst[25:21];
   assign rt    = r_inst[20:16];
   assign rd    = r_inst[15:11];
   assign shamt = r_inst[10:6];
   assign funct = r_inst[5:0];

   assign inst       = r_inst;
   assign out_valid  = r_out_valid;
   assign pc         = r_pc;
   assign busy       = (r_state == ST_FETCH) || (r_state == ST_VALID);
   assign halted     = (r_state == ST_HALT);
   assign illegal    = r_illegal;
   assign inst_count = r_count;

endmodule

// File: tb/tb_r_inst_fetch.sv
// Testbench for r_inst_fetch: directed programs with a scoreboard of expected
// transfers, checked by an independent monitor on every accepted handshake.
module tb_r_inst_fetch;

   logic        clk;
   logic        rst;
   logic        start;
   logic        imem_we;
   logic [5:0]  imem_waddr;
   logic [31:0] imem_wdata;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] inst;
   logic [4:0]  rs;
   logic [4:0]  rt;
   logic [4:0]  rd;
   logic [4:0]  shamt;
   logic [5:0]  funct;
   logic [5:0]  pc;
   logic        busy;
   logic        halted;
   logic        illegal;
   logic [15:0] inst_count;

   typedef struct {
      logic [31:0] inst;
      logic [5:0]  pc;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [4:0]  rd;
      logic [4:0]  shamt;
      logic [5:0]  funct;
   } xfer_t;

   xfer_t expQ[$];
   int    vecCount  = 0;
   int    missCount = 0;

   r_inst_fetch #(.ADDR_W(6), .END_MARK(32'hFFFF_FFFF)) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .imem_we    (imem_we),
      .imem_waddr (imem_waddr),
      .imem_wdata (imem_wdata),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .inst       (inst),
      .rs         (rs),
      .rt         (rt),
      .rd         (rd),
      .shamt      (shamt),
      .funct      (funct),
      .pc         (pc),
      .busy       (busy),
      .halted     (halted),
      .illegal    (illegal),
      .inst_count (inst_count)
   );

   // Free-running clock, period 10.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Hard stop in case something never terminates.
   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      vecCount++;
      if (act !== exp) begin
         missCount++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input logic we, input logic [5:0] waddr, input logic [31:0] wdata,
                                input logic st, input logic rdy);
      @(negedge clk);
      imem_we    = we;
      imem_waddr = waddr;
      imem_wdata = wdata;
      start      = st;
      out_ready  = rdy;
   endtask

   task automatic loadWord(input logic [5:0] a, input logic [31:0] d);
      applyStimulus(1'b1, a, d, 1'b0, 1'b1);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
   endtask

   task automatic expectXfer(input logic [31:0] i, input logic [5:0] p, input logic [4:0] s,
                             input logic [4:0] t, input logic [4:0] d, input logic [4:0] sh,
                             input logic [5:0] f);
      xfer_t e;
      e.inst = i; e.pc = p; e.rs = s; e.rt = t; e.rd = d; e.shamt = sh; e.funct = f;
      expQ.push_back(e);
   endtask

   task automatic waitHalt(input int budget);
      int n = 0;
      while (halted !== 1'b1 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (halted !== 1'b1) begin
         missCount++;
         vecCount++;
         $display("[TB] FAIL wait_halt: got halted=%0b, expected 1 within %0d cycles", halted, budget);
      end
   endtask

   task automatic waitValid(input int budget);
      int n = 0;
      while (out_valid !== 1'b1 && n < budget) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (out_valid !== 1'b1) begin
         missCount++;
         vecCount++;
         $display("[TB] FAIL wait_valid: got out_valid=%0b, expected 1 within %0d cycles", out_valid, budget);
      end
   endtask

   // Monitor: every handshake that the next rising edge will accept is
   // compared against the oldest expected transfer.
   initial begin
      xfer_t e;
      forever begin
         @(negedge clk);
         #2;
         if (rst === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (expQ.size() == 0) begin
               vecCount++;
               missCount++;
               $display("[TB] FAIL unexpected_xfer: got inst=0x%0h pc=%0d, expected no transfer", inst, pc);
            end else begin
               e = expQ.pop_front();
               checkOutput("xfer_inst",  inst,  e.inst);
               checkOutput("xfer_pc",    32'(pc),    32'(e.pc));
               checkOutput("xfer_rs",    32'(rs),    32'(e.rs));
               checkOutput("xfer_rt",    32'(rt),    32'(e.rt));
               checkOutput("xfer_rd",    32'(rd),    32'(e.rd));
               checkOutput("xfer_shamt", 32'(shamt), 32'(e.shamt));
               checkOutput("xfer_funct", 32'(funct), 32'(e.funct));
            end
         end
      end
   end

   // Directed test sequence.
   initial begin
      rst        = 1'b0;
      start      = 1'b0;
      imem_we    = 1'b0;
      imem_waddr = 6'd0;
      imem_wdata = 32'd0;
      out_ready  = 1'b0;
      #1;
      checkOutput("rst_out_valid", 32'(out_valid),  32'd0);
      checkOutput("rst_pc",        32'(pc),         32'd0);
      checkOutput("rst_inst",      inst,            32'd0);
      checkOutput("rst_count",     32'(inst_count), 32'd0);
      checkOutput("rst_halted",    32'(halted),     32'd0);
      checkOutput("rst_illegal",   32'(illegal),    32'd0);
      checkOutput("rst_busy",      32'(busy),       32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // Two R-type instructions then the sentinel, ready always high.
      loadWord(6'd0, 32'h0022_1820);
      loadWord(6'd1, 32'h0085_3022);
      loadWord(6'd2, 32'hFFFF_FFFF);
      expectXfer(32'h0022_1820, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      expectXfer(32'h0085_3022, 6'd1, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("lat_fetch_valid", 32'(out_valid), 32'd0);
      checkOutput("lat_fetch_busy",  32'(busy),      32'd1);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("lat_valid", 32'(out_valid), 32'd1);
      waitHalt(50);
      checkOutput("t1_illegal", 32'(illegal),    32'd0);
      checkOutput("t1_count",   32'(inst_count), 32'd2);
      checkOutput("t1_pc",      32'(pc),         32'd2);

      // Back-pressure: the first instruction is held for five cycles.
      expectXfer(32'h0022_1820, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      expectXfer(32'h0085_3022, 6'd1, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 1'b0);
      waitValid(20);
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1;
         checkOutput("hold_valid", 32'(out_valid), 32'd1);
         checkOutput("hold_inst",  inst,           32'h0022_1820);
         checkOutput("hold_pc",    32'(pc),        32'd0);
      end
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
      @(negedge clk);
      #1;
      checkOutput("hold_count_release", 32'(inst_count), 32'd1);
      waitHalt(50);
      checkOutput("t2_count", 32'(inst_count), 32'd2);

      // Writes during FETCH/VALID are ignored; reset drops the held instruction.
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 1'b0);
      applyStimulus(1'b1, 6'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      applyStimulus(1'b1, 6'd0, 32'hFFFF_FFFF, 1'b0, 1'b0);
      #1;
      checkOutput("t5_valid_before_rst", 32'(out_valid), 32'd1);
      @(negedge clk);
      rst     = 1'b0;
      imem_we = 1'b0;
      #1;
      checkOutput("t5_rst_valid",  32'(out_valid),  32'd0);
      checkOutput("t5_rst_pc",     32'(pc),         32'd0);
      checkOutput("t5_rst_busy",   32'(busy),       32'd0);
      checkOutput("t5_rst_halted", 32'(halted),     32'd0);
      checkOutput("t5_rst_count",  32'(inst_count), 32'd0);
      @(negedge clk);
      rst = 1'b1;
      expectXfer(32'h0022_1820, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      expectXfer(32'h0085_3022, 6'd1, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 1'b1);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
      waitHalt(50);
      checkOutput("t5_readback_count", 32'(inst_count), 32'd2);

      // Non-R-type opcode at address 1 halts with illegal set.
      loadWord(6'd1, 32'h8C22_0004);
      expectXfer(32'h0022_1820, 6'd0, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 1'b1);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
      waitHalt(50);
      checkOutput("t3_illegal", 32'(illegal),    32'd1);
      checkOutput("t3_count",   32'(inst_count), 32'd1);
      checkOutput("t3_pc",      32'(pc),         32'd1);
      checkOutput("t3_valid",   32'(out_valid),  32'd0);

      // Restart from HALT clears illegal; address 0 rewritten on the start edge.
      loadWord(6'd1, 32'h0085_3022);
      expectXfer(32'h00A6_3820, 6'd0, 5'd5, 5'd6, 5'd7, 5'd0, 6'h20);
      expectXfer(32'h0085_3022, 6'd1, 5'd4, 5'd5, 5'd6, 5'd0, 6'h22);
      applyStimulus(1'b1, 6'd0, 32'h00A6_3820, 1'b1, 1'b1);
      @(posedge clk);
      #1;
      checkOutput("t6_illegal_clr", 32'(illegal),    32'd0);
      checkOutput("t6_count_clr",   32'(inst_count), 32'd0);
      checkOutput("t6_pc_clr",      32'(pc),         32'd0);
      checkOutput("t6_busy",        32'(busy),       32'd1);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
      waitHalt(50);
      checkOutput("t6_illegal_end", 32'(illegal),    32'd0);
      checkOutput("t6_count_end",   32'(inst_count), 32'd2);

      // Full memory of R-type words: stops at the last address without wrapping.
      for (int i = 0; i < 64; i++) begin
         loadWord(6'(i), 32'h0000_0020);
      end
      for (int i = 0; i < 64; i++) begin
         expectXfer(32'h0000_0020, 6'(i), 5'd0, 5'd0, 5'd0, 5'd0, 6'h20);
      end
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b1, 1'b1);
      applyStimulus(1'b0, 6'd0, 32'd0, 1'b0, 1'b1);
      waitHalt(400);
      checkOutput("t4_pc",      32'(pc),         32'd63);
      checkOutput("t4_count",   32'(inst_count), 32'd64);
      checkOutput("t4_illegal", 32'(illegal),    32'd0);
      repeat (3) @(negedge clk);
      #1;
      checkOutput("t4_pc_no_wrap", 32'(pc), 32'd63);

      checkOutput("sb_empty", 32'(expQ.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
      $finish;
   end

endmodule
